// File: rtl/sync_fifo_pkg.sv
// -----------------------------------------------------------------------------
// sync_fifo_pkg
// Shared constants and helpers for the synchronous FIFO slice.
//   DEF_*      : default parameter values used by sync_fifo and sync_fifo_mem
//   ptr_width  : pointer/count width for a given depth (address bits + wrap bit)
//   is_pow2    : elaboration-time sanity check for the depth parameter
// -----------------------------------------------------------------------------
package sync_fifo_pkg;

  localparam int DEF_DATA_W   = 8;
  localparam int DEF_DEPTH    = 16;
  localparam int DEF_AF_LEVEL = 14;
  localparam int DEF_AE_LEVEL = 2;

  // One extra bit over the address width: for pointers it is the wrap bit,
  // for the count it lets the value reach DEPTH itself.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic bit is_pow2(input int value);
    return (value >= 2) && ((value & (value - 1)) == 0);
  endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// -----------------------------------------------------------------------------
// sync_fifo_mem
// Simple dual-port storage for sync_fifo: one write port, one read port with a
// registered output. Written so it maps onto inferred block RAM.
//   clk      : clock, rising edge
//   rst      : synchronous active-high reset, clears only the read register
//   wr_en    : write strobe
//   wr_addr  : write address
//   wr_data  : write word
//   rd_en    : read strobe; rd_data updates on the next edge, otherwise holds
//   rd_addr  : read address
//   rd_data  : registered read word
// -----------------------------------------------------------------------------
module sync_fifo_mem
  import sync_fifo_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = $clog2(DEF_DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  localparam int DEPTH = 1 << ADDR_W;

  // Array contents are deliberately not reset so the tools can use RAM.
  logic [DATA_W-1:0] mem_reg [DEPTH];
  logic [DATA_W-1:0] rd_data_reg;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_reg[wr_addr] <= wr_data;
    end
  end

  // Output register: reset to zero, holds its value when no read is issued.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_reg <= '0;
    end else if (rd_en) begin
      rd_data_reg <= mem_reg[rd_addr];
    end
  end

  assign rd_data = rd_data_reg;

endmodule

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with registered read data and registered status flags.
//   clk          : clock, all state updates on the rising edge
//   rst          : synchronous active-high reset, discards all contents
//   wr_en/wr_data: write request and word (ignored while full)
//   rd_en        : read request (ignored while empty)
//   rd_data      : read word, valid the cycle after an accepted read
//   rd_valid     : high exactly in the cycle after an accepted read
//   full/empty/almost_full/almost_empty : registered status flags
//   count        : number of stored words, 0..DEPTH
// Optional build macro SYNC_FIFO_ERR_EN adds:
//   err_clr      : clears the sticky error flags
//   overflow     : sticky, set by a write attempt while full
//   underflow    : sticky, set by a read attempt while empty
// -----------------------------------------------------------------------------
module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int AF_LEVEL = DEF_AF_LEVEL,
  parameter int AE_LEVEL = DEF_AE_LEVEL
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        wr_en,
  input  logic [DATA_W-1:0]           wr_data,
  input  logic                        rd_en,
  output logic [DATA_W-1:0]           rd_data,
  output logic                        rd_valid,
  output logic                        full,
  output logic                        empty,
  output logic                        almost_full,
  output logic                        almost_empty,
  output logic [ptr_width(DEPTH)-1:0] count
`ifdef SYNC_FIFO_ERR_EN
  ,
  input  logic                        err_clr,
  output logic                        overflow,
  output logic                        underflow
`endif
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int PTR_W  = ptr_width(DEPTH);

  localparam logic [PTR_W-1:0] AF_THRESH = PTR_W'(AF_LEVEL);
  localparam logic [PTR_W-1:0] AE_THRESH = PTR_W'(AE_LEVEL);

  // Reject configurations the pointer arithmetic cannot support.
  generate
    if (!is_pow2(DEPTH)) begin : g_bad_depth
      $error("sync_fifo: DEPTH must be a power of two and at least 2");
    end
    if (AF_LEVEL > DEPTH) begin : g_bad_af
      $error("sync_fifo: AF_LEVEL must not exceed DEPTH");
    end
    if (AE_LEVEL >= DEPTH) begin : g_bad_ae
      $error("sync_fifo: AE_LEVEL must be below DEPTH");
    end
    if (DATA_W < 1) begin : g_bad_width
      $error("sync_fifo: DATA_W must be at least 1");
    end
  endgenerate

  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [PTR_W-1:0] count_reg, count_next;
  logic             full_reg, full_next;
  logic             empty_reg, empty_next;
  logic             almost_full_reg, almost_full_next;
  logic             almost_empty_reg, almost_empty_next;
  logic             rd_valid_reg;
  logic             wr_accept;
  logic             rd_accept;

  // Acceptance looks only at the registered flags, so a read on a full FIFO
  // never frees room for a same-cycle write, and a write on an empty FIFO is
  // never read through in the same cycle. Reset blocks both.
  always_comb begin
    wr_accept = wr_en && !full_reg  && !rst;
    rd_accept = rd_en && !empty_reg && !rst;
  end

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;

    if (wr_accept) begin
      wr_ptr_next = wr_ptr_reg + PTR_W'(1);
    end
    if (rd_accept) begin
      rd_ptr_next = rd_ptr_reg + PTR_W'(1);
    end

    case ({wr_accept, rd_accept})
      2'b10:   count_next = count_reg + PTR_W'(1);
      2'b01:   count_next = count_reg - PTR_W'(1);
      default: count_next = count_reg;
    endcase

    // Flags come from next-state values so they line up with count.
    full_next  = (wr_ptr_next[PTR_W-1] != rd_ptr_next[PTR_W-1]) &&
                 (wr_ptr_next[ADDR_W-1:0] == rd_ptr_next[ADDR_W-1:0]);
    empty_next = (wr_ptr_next == rd_ptr_next);
    almost_full_next  = (count_next >= AF_THRESH);
    almost_empty_next = (count_next <= AE_THRESH);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg       <= '0;
      rd_ptr_reg       <= '0;
      count_reg        <= '0;
      full_reg         <= 1'b0;
      empty_reg        <= 1'b1;
      almost_full_reg  <= 1'b0;
      almost_empty_reg <= 1'b1;
      rd_valid_reg     <= 1'b0;
    end else begin
      wr_ptr_reg       <= wr_ptr_next;
      rd_ptr_reg       <= rd_ptr_next;
      count_reg        <= count_next;
      full_reg         <= full_next;
      empty_reg        <= empty_next;
      almost_full_reg  <= almost_full_next;
      almost_empty_reg <= almost_empty_next;
      rd_valid_reg     <= rd_accept;
    end
  end

  // Both ports are never accepted on the same address: simultaneous accepts
  // imply 0 < count < DEPTH, so the pointers differ.
  sync_fifo_mem #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_accept),
    .wr_addr (wr_ptr_reg[ADDR_W-1:0]),
    .wr_data (wr_data),
    .rd_en   (rd_accept),
    .rd_addr (rd_ptr_reg[ADDR_W-1:0]),
    .rd_data (rd_data)
  );

  assign rd_valid     = rd_valid_reg;
  assign full         = full_reg;
  assign empty        = empty_reg;
  assign almost_full  = almost_full_reg;
  assign almost_empty = almost_empty_reg;
  assign count        = count_reg;

`ifdef SYNC_FIFO_ERR_EN
  logic overflow_reg;
  logic underflow_reg;

  // Sticky error flags; a new error event wins over a same-cycle clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      if (wr_en && full_reg) begin
        overflow_reg <= 1'b1;
      end else if (err_clr) begin
        overflow_reg <= 1'b0;
      end
      if (rd_en && empty_reg) begin
        underflow_reg <= 1'b1;
      end else if (err_clr) begin
        underflow_reg <= 1'b0;
      end
    end
  end

  assign overflow  = overflow_reg;
  assign underflow = underflow_reg;
`endif

endmodule

// File: doc/sync_fifo.md
SYNC_FIFO -- requirements
Module: sync_fifo

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8: data word width in bits, at least 1.
REQ-002 The block SHALL have parameter DEPTH, default 16: number of entries, a power of two, at least 2.
REQ-003 The block SHALL have parameter AF_LEVEL, default 14: almost_full asserts when count >= AF_LEVEL.
REQ-004 The block SHALL have parameter AE_LEVEL, default 2: almost_empty asserts when count <= AE_LEVEL.
REQ-005 The block SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 The block SHALL have port wr_en, input, 1 bit: write request.
REQ-008 The block SHALL have port wr_data, input, DATA_W bits: write word.
REQ-009 The block SHALL have port rd_en, input, 1 bit: read request.
REQ-010 The block SHALL have port rd_data, output, DATA_W bits: read word, registered.
REQ-011 The block SHALL have port rd_valid, output, 1 bit: rd_data carries a newly read word this cycle.
REQ-012 The block SHALL have ports full, empty, almost_full and almost_empty, each output, 1 bit, each a registered status flag.
REQ-013 The block SHALL have port count, output, $clog2(DEPTH)+1 bits: number of stored words, 0..DEPTH.

Function
REQ-014 A write SHALL be accepted iff wr_en=1 and full=0; the word is stored at the write pointer, and the pointer advances modulo DEPTH.
REQ-015 A read SHALL be accepted iff rd_en=1 and empty=0; the word at the read pointer appears on rd_data one cycle later with rd_valid=1, and the pointer advances modulo DEPTH.
REQ-016 rd_valid SHALL be 0 in every cycle not directly following an accepted read, and rd_data SHALL hold its last value in those cycles.
REQ-017 A write while full and a read while empty SHALL be ignored, with no change to state, pointers or count.
REQ-018 An accepted read and an accepted write in the same cycle SHALL leave count unchanged and SHALL both complete.
REQ-019 When the FIFO is full, rd_en=1 with wr_en=1 SHALL accept only the read; the write is dropped.
REQ-020 When the FIFO is empty, rd_en=1 with wr_en=1 SHALL accept only the write; there is no fall-through.
REQ-021 The pointers SHALL carry one extra wrap bit; full is (MSBs differ, remaining bits equal); empty is (pointers equal).
REQ-022 All four flags SHALL be computed from the next-state count, so they are valid in the same cycle that count updates.
REQ-023 Data order SHALL be strict FIFO across any number of pointer wrap-arounds.

Reset
REQ-024 With rst=1 at a rising edge, the block SHALL set pointers=0, count=0, empty=1, almost_empty=1, full=0, almost_full=0, rd_valid=0 and rd_data=0.
REQ-025 rst SHALL dominate wr_en and rd_en in the same cycle, and SHALL discard all stored contents even mid-operation.
REQ-026 Storage array contents SHALL NOT be reset.

Configuration
REQ-027 With macro SYNC_FIFO_ERR_EN defined, the block SHALL add input err_clr (1 bit) and sticky outputs overflow and underflow (1 bit each).
REQ-028 With SYNC_FIFO_ERR_EN defined, overflow SHALL set on wr_en=1 while full=1 and underflow SHALL set on rd_en=1 while empty=1; each clears on err_clr=1 or rst=1, and a set event in the same cycle as err_clr leaves the flag set.
REQ-029 Without SYNC_FIFO_ERR_EN, those ports and their logic SHALL NOT exist, and all other behaviour SHALL be identical.

Structure
REQ-030 Package sync_fifo_pkg SHALL hold the default parameter constants and a function computing pointer/count width from DEPTH.
REQ-031 Storage SHALL be a sub-module sync_fifo_mem: a simple dual-port array with one write port and a registered read port.
REQ-032 Elaboration SHALL fail if DEPTH is not a power of two, or if AF_LEVEL > DEPTH or AE_LEVEL >= DEPTH.

Verification
REQ-033 Scenario: reset, then write 0x01..0x10 in consecutive cycles -> full=1 and count=16 after the 16th write, almost_full=1 from count=14, and a 17th write of 0xFF is ignored.
REQ-034 Scenario: from full, read 16 times -> rd_data 0x01..0x10 in order, each with rd_valid one cycle after rd_en, empty=1 after the last read, and almost_empty=1 from count=2.
REQ-035 Scenario: at count=5, hold wr_en=rd_en=1 for 40 cycles -> count stays 5 and output data is in order across 2+ pointer wraps.
REQ-036 Scenario: from empty, wr_en=rd_en=1 with 0xAA -> write accepted, rd_valid=0 next cycle, count=1; from full, same stimulus -> count=15 and the write is dropped.
REQ-037 Scenario: at count=9, assert rst with wr_en=1 -> next cycle count=0, empty=1, rd_valid=0 and rd_data=0.
REQ-038 Scenario: with SYNC_FIFO_ERR_EN defined, read while empty -> underflow=1 and held; pulse err_clr -> underflow=0; write while full -> overflow=1.
